// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand stage ahead of the 16-bit ALU.
// Holds the register file, a per-register pending scoreboard, the Bin
// immediate select and 1-bit shifter, and a registered Ain/Bin/ALUop bundle
// handed over on a valid/ready handshake.
// Build option: define OPERAND_BYPASS_EN to forward a same-cycle writeback to
// operand reads and drop the matching stall term (zero-bubble dependent issue).
module alu_operand_stage #(
    parameter int NREGS = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(NREGS)-1:0] rn,
    input  logic [$clog2(NREGS)-1:0] rm,
    input  logic [$clog2(NREGS)-1:0] rd,
    input  logic                     rd_en,
    input  logic                     asel,
    input  logic                     bsel,
    input  logic [4:0]               imm5,
    input  logic [1:0]               shift,
    input  logic [1:0]               op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         Ain,
    output logic [WIDTH-1:0]         Bin,
    output logic [1:0]               ALUop,
    input  logic                     wb_en,
    input  logic [$clog2(NREGS)-1:0] wb_num,
    input  logic [WIDTH-1:0]         wb_data
);

    logic [WIDTH-1:0] rf [NREGS];
    logic [NREGS-1:0] pend;

    logic             pend_a, pend_b, stall, in_fire;
    logic [WIDTH-1:0] a_src, b_src, a_next, b_pre, b_next;
    logic [NREGS-1:0] set_vec, clr_vec;

`ifdef OPERAND_BYPASS_EN
    logic hit_a, hit_b;

    // Register read with writeback forwarding; a register being written this
    // cycle is no longer a hazard because its pending bit is clearing.
    always_comb begin
        hit_a  = wb_en & (wb_num == rn);
        hit_b  = wb_en & (wb_num == rm);
        a_src  = hit_a ? wb_data : rf[rn];
        b_src  = hit_b ? wb_data : rf[rm];
        pend_a = pend[rn] & ~hit_a;
        pend_b = pend[rm] & ~hit_b;
    end
`else
    // Plain register read: a same-cycle writeback is seen only next cycle.
    always_comb begin
        a_src  = rf[rn];
        b_src  = rf[rm];
        pend_a = pend[rn];
        pend_b = pend[rm];
    end
`endif

    // Operand formation, hazard detection and handshake.
    always_comb begin
        a_next = asel ? '0 : a_src;
        b_pre  = bsel ? {{(WIDTH-5){imm5[4]}}, imm5} : b_src;
        case (shift)
            2'b00:   b_next = b_pre;
            2'b01:   b_next = {b_pre[WIDTH-2:0], 1'b0};
            2'b10:   b_next = {1'b0, b_pre[WIDTH-1:1]};
            default: b_next = {b_pre[WIDTH-1], b_pre[WIDTH-1:1]};
        endcase
        // Unused sources never stall.
        stall    = (~asel & pend_a) | (~bsel & pend_b);
        in_ready = ~stall & (~out_valid | out_ready);
        in_fire  = in_valid & in_ready;
        set_vec  = '0;
        clr_vec  = '0;
        if (in_fire & rd_en) set_vec[rd] = 1'b1;
        if (wb_en)           clr_vec[wb_num] = 1'b1;
    end

    // State update: register file, scoreboard (set beats clear) and output bundle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
            pend      <= '0;
            out_valid <= 1'b0;
            Ain       <= '0;
            Bin       <= '0;
            ALUop     <= '0;
        end else begin
            if (wb_en) rf[wb_num] <= wb_data;
            pend <= (pend & ~clr_vec) | set_vec;
            if (in_fire) begin
                Ain       <= a_next;
                Bin       <= b_next;
                ALUop     <= op;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Pipeline stage directly upstream of the 16-bit ALU. It holds the 8-entry x 16-bit register file, a per-register pending scoreboard, the Bin shifter and immediate select.
- Drives a registered Ain/Bin/ALUop bundle to the ALU over a valid/ready handshake.
- Accepts writebacks of ALU results, which clear scoreboard entries.

Parameters:
- NREGS, 8, register-file depth; register index width is clog2(NREGS).
- WIDTH, 16, datapath width; must match ALU Ain/Bin.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  issue request valid
- in_ready  out  1  stage accepts issue this cycle
- rn  in  3  source register for Ain
- rm  in  3  source register for Bin
- rd  in  3  destination register marked pending on issue
- rd_en  in  1  issue writes rd (sets pending)
- asel  in  1  1: Ain = 0, rn not read
- bsel  in  1  1: Bin = sign-extended imm5, rm not read
- imm5  in  5  immediate
- shift  in  2  Bin shift: 00 none, 01 LSL1, 10 LSR1 zero-fill, 11 ASR1
- op  in  2  ALUop passthrough (00 ADD, 01 SUB, 10 AND, 11 NOT)
- out_valid  out  1  Ain/Bin/ALUop valid
- out_ready  in  1  ALU side consumes
- Ain  out  16  registered operand A
- Bin  out  16  registered operand B
- ALUop  out  2  registered op
- wb_en  in  1  writeback strobe
- wb_num  in  3  writeback register
- wb_data  in  16  writeback value

Behaviour:
- Reset (synchronous, active-high, one cycle): all registers, Ain, Bin and ALUop go to 0; out_valid=0; all pending bits=0. Reset mid-transfer discards the held bundle.
- Output register: in_ready = ~stall & (~out_valid | out_ready).
  - in_fire = in_valid & in_ready. On in_fire, load Ain/Bin/ALUop and set out_valid=1.
  - If out_valid & out_ready & ~in_fire, set out_valid=0.
  - While out_valid & ~out_ready, Ain/Bin/ALUop hold stable.
- Latency: issue to out_valid is 1 cycle. Throughput is 1 per cycle when out_ready is held high.
- Operand formation:
  - Ain = asel ? 0 : R[rn].
  - Bin = shift applied to (bsel ? sext(imm5) : R[rm]). The shift applies to the immediate as well.
  - Shifts are 16-bit, 1 position. ASR replicates bit 15. The bit shifted out is dropped.
- Scoreboard:
  - stall = 1 when a used source is pending: (~asel & pend[rn]) | (~bsel & pend[rm]). An unused source never stalls.
  - On in_fire & rd_en, set pend[rd].
  - On wb_en, write R[wb_num]=wb_data and clear pend[wb_num].
  - Same cycle, same register, issue set and wb clear: set wins; the register stays pending.
  - wb to a non-pending register writes normally.
- Read/write collision: writeback and operand read of the same register in the same cycle is governed by OPERAND_BYPASS_EN.
- Register index values are always within 0..7; there is no out-of-range case.

Optional Feature:
- Macro: OPERAND_BYPASS_EN.
- Defined:
  - An operand read of register X while wb_en & wb_num==X in the same cycle returns wb_data.
  - The stall term for X is suppressed that cycle, because the pending bit is clearing.
  - Zero-bubble back-to-back dependent issue is possible.
- Undefined:
  - Reads return the pre-write register value.
  - pend[X] still stalls in the wb cycle; the dependent issue fires the following cycle.

Test Plan:
- Reset-state check: assert reset 1 cycle -> out_valid=0, Ain=Bin=0, ALUop=0, in_ready=1. After wb R2=0x1234 and issue rn=2, rm=2, shift=00, op=00 -> next cycle Ain=0x1234, Bin=0x1234, ALUop=00, out_valid=1.
- Shift and immediate forms: R3=0x8001.
  - shift 01 -> Bin=0x0002.
  - shift 10 -> Bin=0x4000.
  - shift 11 -> Bin=0xC000.
  - bsel=1, imm5=5'b10000, shift 00 -> Bin=0xFFF0.
  - asel=1 -> Ain=0 regardless of rn.
- Backpressure: out_ready=0 with 2 issues offered -> first captured and held stable, second not accepted (in_ready=0). Raise out_ready -> second loads the next cycle with no loss or duplication.
- Scoreboard stall: issue rd=4, rd_en=1, then issue reading rn=4 -> in_ready=0 until wb_num=4.
  - Without macro: fires the cycle after wb.
  - With OPERAND_BYPASS_EN: fires in the wb cycle with Ain=wb_data.
  - asel=1 with rn=4 pending -> no stall.
- Set/clear collision: pend[5] set, then same cycle issue rd=5, rd_en=1 and wb_num=5 -> R5=wb_data, pend[5] remains 1; a subsequent read of R5 stalls.
- Reset mid-operation: out_valid=1, out_ready=0, pend[1]=1, assert reset -> next cycle out_valid=0, all pend=0, R1=0.
